// File: rtl/frame_mem_writer_pkg.sv
// Shared types and constants for the frame buffer write stage.
package frame_mem_writer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_DE,
    ACTIVE
  } Wstate_t;

  localparam int unsigned PIX_PER_WORD = 4;
  localparam logic [15:0] CRC16_INIT   = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY   = 16'h1021;

endpackage

// File: rtl/frame_mem_writer_if.sv
// Pixel stream in and FRAMEMEM write port out; master is the writer side.
interface frame_mem_writer_if #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 15
);
  logic                    i_vsync;
  logic                    i_de;
  logic [DATA_WIDTH-1:0]   i_data;
  logic                    o_fmem_csn;
  logic                    o_fmem_wen;
  logic [ADDR_WIDTH-1:0]   o_fmem_addr;
  logic [4*DATA_WIDTH-1:0] o_fmem_din;

  modport master (
    input  i_vsync, i_de, i_data,
    output o_fmem_csn, o_fmem_wen, o_fmem_addr, o_fmem_din
  );

  modport slave (
    output i_vsync, i_de, i_data,
    input  o_fmem_csn, o_fmem_wen, o_fmem_addr, o_fmem_din
  );
endinterface

// File: rtl/frame_mem_writer_crc16.sv
// CRC-16-CCITT update over one 24-bit pixel, MSB first (built only with FMEM_WR_CRC_EN).
`ifdef FMEM_WR_CRC_EN
module crc16_ccitt24
  import frame_mem_writer_pkg::*;
(
  input  logic [15:0] crc,
  input  logic [23:0] data,
  output logic [15:0] crc_next
);
  logic        fb;
  logic [15:0] acc;

  always_comb begin
    acc = crc;
    fb  = 1'b0;
    for (int unsigned i = 0; i < 24; i++) begin
      fb  = acc[15] ^ data[23 - i];
      acc = {acc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    end
    crc_next = acc;
  end
endmodule
`endif

// File: rtl/frame_mem_writer.sv
// Packs four pixels per FRAMEMEM word, tracks line/frame geometry and errors.
// Optional frame CRC enabled by FMEM_WR_CRC_EN; otherwise o_frame_crc is 0.
module frame_mem_writer
  import frame_mem_writer_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int HRES       = 320,
  parameter int VRES       = 240,
  parameter int ADDR_DEPTH = HRES * VRES / 4,
  parameter int ADDR_WIDTH = $clog2(ADDR_DEPTH)
) (
  input  logic                      i_clk,
  input  logic                      rst,
  frame_mem_writer_if.master        bus,
  output logic                      o_frame_done,
  output logic                      o_err_line,
  output logic                      o_err_frame,
  output logic [15:0]               o_frame_crc
);

  localparam int PIX_W   = $clog2(HRES + 2);
  localparam int LINE_W  = $clog2(VRES + 1);
  localparam int WADDR_W = $clog2(ADDR_DEPTH + 1);

  localparam logic [PIX_W-1:0]   PIX_FULL  = PIX_W'(HRES);
  localparam logic [PIX_W-1:0]   PIX_SAT   = PIX_W'(HRES + 1);
  localparam logic [LINE_W-1:0]  LINE_MAX  = LINE_W'(VRES);
  localparam logic [LINE_W-1:0]  LINE_LAST = LINE_W'(VRES - 1);
  localparam logic [WADDR_W-1:0] ADDR_END  = WADDR_W'(ADDR_DEPTH);

  Wstate_t state, state_nxt;

  logic                                      vsync_q;
  logic                                      de_q;
  logic [1:0]                                lane_cnt;
  logic [PIX_W-1:0]                          pix_cnt;
  logic [LINE_W-1:0]                         line_cnt;
  logic [WADDR_W-1:0]                        waddr;
  logic [PIX_PER_WORD-1:0][DATA_WIDTH-1:0]   pack;
  logic                                      done_pend;
  logic                                      err_clr;

  logic                    vs_rise, in_frame, pix_in, pix_wr, line_end;
  logic                    premature, frame_end, wr_req, overflow;
  logic [1:0]              lane_cur;
  logic [WADDR_W-1:0]      addr_cur;
  logic [PIX_W-1:0]        pix_cur;
  logic [4*DATA_WIDTH-1:0] wr_din;

  always_ff @(posedge i_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (vs_rise) begin
      state_nxt = WAIT_DE;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        WAIT_DE: if (bus.i_de)  state_nxt = ACTIVE;
        ACTIVE:  if (!bus.i_de) state_nxt = WAIT_DE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // A vsync rise restarts the frame in the same cycle, so the *_cur values
  // let a coincident pixel land in lane 0 of address 0.
  always_comb begin
    vs_rise   = bus.i_vsync && !vsync_q;
    lane_cur  = vs_rise ? '0 : lane_cnt;
    addr_cur  = vs_rise ? '0 : waddr;
    pix_cur   = vs_rise ? '0 : pix_cnt;
    in_frame  = (state != IDLE) || vs_rise;
    pix_in    = in_frame && bus.i_de;
    pix_wr    = pix_in && (vs_rise || line_cnt != LINE_MAX);
    line_end  = !vs_rise && de_q && !bus.i_de;
    premature = vs_rise && line_cnt != '0 && line_cnt != LINE_MAX;
    frame_end = line_end && line_cnt == LINE_LAST;
    wr_req    = 1'b0;
    wr_din    = '0;
    if (pix_wr && lane_cur == 2'd3) begin
      wr_req = 1'b1;
      wr_din = {bus.i_data, pack[2], pack[1], pack[0]};
    end else if (line_end && lane_cnt != 2'd0) begin
      wr_req = 1'b1;
      wr_din = pack;
    end
    overflow = wr_req && addr_cur == ADDR_END;
  end

  always_ff @(posedge i_clk) begin
    if (rst) begin
      vsync_q         <= bus.i_vsync;
      de_q            <= 1'b0;
      lane_cnt        <= '0;
      pix_cnt         <= '0;
      line_cnt        <= '0;
      waddr           <= '0;
      pack            <= '0;
      done_pend       <= 1'b0;
      err_clr         <= 1'b0;
      bus.o_fmem_csn  <= 1'b1;
      bus.o_fmem_wen  <= 1'b1;
      bus.o_fmem_addr <= '0;
      bus.o_fmem_din  <= '0;
      o_frame_done    <= 1'b0;
      o_err_line      <= 1'b0;
      o_err_frame     <= 1'b0;
    end else begin
      vsync_q        <= bus.i_vsync;
      de_q           <= pix_in;
      bus.o_fmem_csn <= 1'b1;
      bus.o_fmem_wen <= 1'b1;
      o_frame_done   <= done_pend;
      done_pend      <= 1'b0;
      err_clr        <= 1'b0;
      if (err_clr) o_err_frame <= 1'b0;

      // Premature-frame error is raised on the frame-start edge and
      // withdrawn one cycle later through err_clr.
      if (vs_rise) begin
        waddr       <= '0;
        lane_cnt    <= '0;
        pix_cnt     <= '0;
        line_cnt    <= '0;
        pack        <= '0;
        o_err_line  <= 1'b0;
        o_err_frame <= premature;
        err_clr     <= premature;
      end

      if (pix_in) begin
        if (pix_cur != PIX_SAT) pix_cnt <= pix_cur + PIX_W'(1);
        if (!pix_wr) o_err_frame <= 1'b1;
      end

      if (pix_wr) begin
        lane_cnt <= lane_cur + 2'd1;
        if (lane_cur == 2'd3) pack <= '0;
        else                  pack[lane_cur] <= bus.i_data;
      end

      if (line_end) begin
        if (pix_cnt != PIX_FULL) o_err_line <= 1'b1;
        lane_cnt <= '0;
        pix_cnt  <= '0;
        pack     <= '0;
        if (line_cnt != LINE_MAX) line_cnt <= line_cnt + LINE_W'(1);
        if (frame_end) begin
          if (lane_cnt != 2'd0) done_pend    <= 1'b1;
          else                  o_frame_done <= 1'b1;
        end
      end

      if (wr_req) begin
        if (overflow) begin
          o_err_frame <= 1'b1;
        end else begin
          bus.o_fmem_csn  <= 1'b0;
          bus.o_fmem_wen  <= 1'b0;
          bus.o_fmem_addr <= addr_cur[ADDR_WIDTH-1:0];
          bus.o_fmem_din  <= wr_din;
          waddr           <= addr_cur + WADDR_W'(1);
        end
      end
    end
  end

`ifdef FMEM_WR_CRC_EN
  logic [15:0] crc_run, crc_base, crc_step;
  logic [23:0] crc_pix;

  always_comb begin
    crc_base = vs_rise ? CRC16_INIT : crc_run;
    crc_pix  = 24'(bus.i_data);
  end

  crc16_ccitt24 u_crc (
    .crc      (crc_base),
    .data     (crc_pix),
    .crc_next (crc_step)
  );

  always_ff @(posedge i_clk) begin
    if (rst) begin
      crc_run     <= CRC16_INIT;
      o_frame_crc <= '0;
    end else begin
      if (vs_rise)   crc_run     <= CRC16_INIT;
      if (pix_wr)    crc_run     <= crc_step;
      if (frame_end) o_frame_crc <= crc_run;
    end
  end
`else
  assign o_frame_crc = '0;
`endif

endmodule

// File: tb/tb_frame_mem_writer.sv
// Scoreboard bench for frame_mem_writer with HRES=8, VRES=2.
module tb_frame_mem_writer;
  localparam int DW = 24;
  localparam int HR = 8;
  localparam int VR = 2;
  localparam int AD = 4;
  localparam int AW = 2;

`ifdef FMEM_WR_CRC_EN
  localparam logic [15:0] CRC_MASK = 16'hFFFF;
`else
  localparam logic [15:0] CRC_MASK = 16'h0000;
`endif

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [4*DW-1:0] din;
  } wr_t;

  logic        clk;
  logic        rst;
  logic        frame_done, err_line, err_frame;
  logic [15:0] frame_crc;

  frame_mem_writer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  frame_mem_writer #(
    .DATA_WIDTH (DW),
    .HRES       (HR),
    .VRES       (VR),
    .ADDR_DEPTH (AD),
    .ADDR_WIDTH (AW)
  ) dut (
    .i_clk        (clk),
    .rst          (rst),
    .bus          (bus),
    .o_frame_done (frame_done),
    .o_err_line   (err_line),
    .o_err_frame  (err_frame),
    .o_frame_crc  (frame_crc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_wr = -10;
  int done_seen = 0;
  int done_exp = 0;
  wr_t exp_q[$];
  wr_t mon_e;

  logic [3:0][DW-1:0] m_pack;
  int          m_lane, m_addr, m_lines;
  logic [15:0] m_crc, m_crc_done;
  bit          auto_push;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.o_fmem_csn == 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected got addr=%0h din=%h required no write", bus.o_fmem_addr, bus.o_fmem_din);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.o_fmem_addr !== mon_e.addr || bus.o_fmem_din !== mon_e.din || bus.o_fmem_wen !== 1'b0) begin
          errors++;
          $display("FAIL wr_word got addr=%0h din=%h wen=%b required addr=%0h din=%h wen=0",
                   bus.o_fmem_addr, bus.o_fmem_din, bus.o_fmem_wen, mon_e.addr, mon_e.din);
        end
      end
      last_wr = cyc;
    end
    if (frame_done === 1'b1) begin
      checks++;
      done_seen++;
      if (cyc != last_wr + 1) begin
        errors++;
        $display("FAIL done_timing got %0d cycles after last write required 1", cyc - last_wr);
      end
    end
  end

  function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [23:0] px);
    logic [15:0] r;
    r = c;
    for (int b = 23; b >= 0; b--) begin
      if (r[15] != px[b]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else                r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [4*DW-1:0] got, input logic [4*DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic push(input int a, input logic [4*DW-1:0] d);
    wr_t w;
    w.addr = AW'(a);
    w.din  = d;
    exp_q.push_back(w);
  endtask

  task automatic tick(input logic vs, input logic de, input logic [DW-1:0] d);
    bus.i_vsync = vs;
    bus.i_de    = de;
    bus.i_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic model_pix(input logic [DW-1:0] d);
    if (m_lines < VR) begin
      m_pack[m_lane] = d;
      m_crc = crc_ref(m_crc, d);
      m_lane++;
      if (m_lane == 4) begin
        if (auto_push && m_addr < AD) push(m_addr, m_pack);
        m_addr++;
        m_pack = '0;
        m_lane = 0;
      end
    end
  endtask

  task automatic model_line_end();
    if (m_lines < VR) begin
      if (m_lane != 0) begin
        if (auto_push && m_addr < AD) push(m_addr, m_pack);
        m_addr++;
      end
      m_pack = '0;
      m_lane = 0;
      m_lines++;
      if (m_lines == VR) begin
        done_exp++;
        m_crc_done = m_crc;
      end
    end
  endtask

  task automatic vsync_pulse(input logic de, input logic [DW-1:0] d);
    m_pack  = '0;
    m_lane  = 0;
    m_addr  = 0;
    m_lines = 0;
    m_crc   = 16'hFFFF;
    if (de) model_pix(d);
    tick(1'b1, de, d);
  endtask

  task automatic send_line(input int n, input logic [DW-1:0] base, input logic [DW-1:0] step);
    logic [DW-1:0] px;
    px = base;
    for (int i = 0; i < n; i++) begin
      model_pix(px);
      tick(1'b0, 1'b1, px);
      px = px + step;
    end
    model_line_end();
    tick(1'b0, 1'b0, '0);
    tick(1'b0, 1'b0, '0);
  endtask

  initial begin
    bus.i_vsync = 1'b0;
    bus.i_de    = 1'b0;
    bus.i_data  = '0;
    rst         = 1'b1;
    auto_push   = 1'b1;
    m_pack      = '0;
    m_lane      = 0;
    m_addr      = 0;
    m_lines     = 0;
    m_crc       = 16'hFFFF;
    m_crc_done  = 16'h0000;
    repeat (3) tick(1'b0, 1'b0, '0);

    chk("rst_csn", 96'(bus.o_fmem_csn), 96'd1);
    chk("rst_wen", 96'(bus.o_fmem_wen), 96'd1);
    chk("rst_addr", 96'(bus.o_fmem_addr), 96'd0);
    chk("rst_din", bus.o_fmem_din, 96'd0);
    chk("rst_done", 96'(frame_done), 96'd0);
    chk("rst_err_line", 96'(err_line), 96'd0);
    chk("rst_err_frame", 96'(err_frame), 96'd0);
    chk("rst_crc", 96'(frame_crc), 96'd0);
    rst = 1'b0;

    // de activity before any vsync must not write
    for (int i = 0; i < 6; i++) tick(1'b0, i[0], DW'(32'hA0 + i));
    tick(1'b0, 1'b0, '0);
    chk("idle_csn", 96'(bus.o_fmem_csn), 96'd1);
    chk("idle_err_frame", 96'(err_frame), 96'd0);

    // nominal frame, pixels 1..16, hand-computed words
    auto_push = 1'b0;
    vsync_pulse(1'b0, '0);
    tick(1'b0, 1'b0, '0);
    push(0, {24'h000004, 24'h000003, 24'h000002, 24'h000001});
    push(1, {24'h000008, 24'h000007, 24'h000006, 24'h000005});
    push(2, {24'h00000C, 24'h00000B, 24'h00000A, 24'h000009});
    push(3, {24'h000010, 24'h00000F, 24'h00000E, 24'h00000D});
    send_line(8, 24'h000001, 24'h000001);
    send_line(8, 24'h000009, 24'h000001);
    auto_push = 1'b1;
    chk("nom_err_line", 96'(err_line), 96'd0);
    chk("nom_err_frame", 96'(err_frame), 96'd0);
    chk("nom_done_cnt", 96'(done_seen), 96'd1);
    chk("nom_crc", 96'(frame_crc), 96'(m_crc_done & CRC_MASK));

    // short first line: flush at addr 1 with upper lanes zero
    vsync_pulse(1'b0, '0);
    tick(1'b0, 1'b0, '0);
    send_line(6, 24'h000100, 24'h000001);
    chk("short_err_line", 96'(err_line), 96'd1);
    send_line(8, 24'h000200, 24'h000001);
    chk("short_err_line_sticky", 96'(err_line), 96'd1);
    chk("short_err_frame", 96'(err_frame), 96'd0);
    chk("short_crc", 96'(frame_crc), 96'(m_crc_done & CRC_MASK));

    // premature vsync after one line
    vsync_pulse(1'b0, '0);
    chk("vs_clears_err_line", 96'(err_line), 96'd0);
    chk("vs_err_frame_clear", 96'(err_frame), 96'd0);
    send_line(8, 24'h000300, 24'h000003);
    vsync_pulse(1'b0, '0);
    chk("premature_err_frame", 96'(err_frame), 96'd1);
    tick(1'b0, 1'b0, '0);
    chk("premature_err_clear", 96'(err_frame), 96'd0);
    send_line(8, 24'h000400, 24'h000001);
    send_line(8, 24'h000500, 24'h000001);
    chk("restart_crc", 96'(frame_crc), 96'(m_crc_done & CRC_MASK));

    // extra line after completion: no writes, frame error
    send_line(8, 24'h000600, 24'h000001);
    chk("ovf_err_frame", 96'(err_frame), 96'd1);
    chk("ovf_err_line", 96'(err_line), 96'd0);

    // vsync rise together with the first pixel
    vsync_pulse(1'b1, 24'h000700);
    chk("sim_err_frame", 96'(err_frame), 96'd0);
    send_line(7, 24'h000701, 24'h000001);
    send_line(8, 24'h000800, 24'h000001);
    chk("sim_crc", 96'(frame_crc), 96'(m_crc_done & CRC_MASK));

    // all-zero frame for the CRC golden value
    vsync_pulse(1'b0, '0);
    tick(1'b0, 1'b0, '0);
    send_line(8, '0, '0);
    send_line(8, '0, '0);
    chk("zero_crc", 96'(frame_crc), 96'(m_crc_done & CRC_MASK));

    // reset mid-frame, then de without vsync must stay silent
    vsync_pulse(1'b0, '0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, DW'(32'hB0 + i));
    rst = 1'b1;
    tick(1'b0, 1'b1, 24'h0000B3);
    chk("mid_rst_csn", 96'(bus.o_fmem_csn), 96'd1);
    chk("mid_rst_addr", 96'(bus.o_fmem_addr), 96'd0);
    chk("mid_rst_din", bus.o_fmem_din, 96'd0);
    chk("mid_rst_crc", 96'(frame_crc), 96'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, DW'(32'hC0 + i));
    tick(1'b0, 1'b0, '0);
    tick(1'b0, 1'b0, '0);
    chk("post_rst_err_line", 96'(err_line), 96'd0);

    chk("pending_writes", 96'(exp_q.size()), 96'd0);
    chk("done_count", 96'(done_seen), 96'(done_exp));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
